// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe controller: holds the 3x3 board, cursor and turn, detects win/draw, blinks the win line.
// Latency: game_state/winner/turn/cursor registered (1 cycle); tiles/color one further cycle behind.
// Backpressure: none; buttons are single-cycle pulses and at most one action is taken per cycle.
module ttt_game_ctrl #(
  parameter int unsigned BLINK_CYCLES = 25_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_select,
  input  logic        new_game,
  output logic [17:0] tiles,
  output logic [8:0]  color,
  output logic [1:0]  game_state,
  output logic [1:0]  winner,
  output logic        turn,
  output logic [3:0]  cursor
);

  localparam int unsigned CNT_W = $clog2(BLINK_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_CYCLES - 1);

  // Eight winning lines as 9-bit tile masks: rows, columns, diagonals.
  localparam logic [71:0] LINE_MASKS = {9'h054, 9'h111, 9'h124, 9'h092,
                                        9'h049, 9'h1C0, 9'h038, 9'h007};

  typedef enum logic [1:0] {
    ST_PLAY  = 2'b00,
    ST_CHECK = 2'b01,
    ST_WIN   = 2'b10,
    ST_DRAW  = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [17:0]      board_q, board_d;
  logic [3:0]       cursor_q, cursor_d;
  logic             turn_q, turn_d;
  logic [1:0]       winner_q, winner_d;
  logic [8:0]       mask_q, mask_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;
  logic [17:0]      tiles_q, tiles_d;
  logic [8:0]       color_q, color_d;

  logic [8:0]       occ;
  logic [8:0]       shape;
  logic [8:0]       hit_mask;
  logic [8:0]       line_m;
  logic [3:0]       cur_idx;
  logic [8:0]       cur_onehot;
  logic             cur_empty;
  logic [1:0]       row, col;
  logic [1:0]       row_n, col_n;

  // Split the board into occupancy/shape vectors, sanitise the cursor, OR together all complete lines.
  always_comb begin
    occ      = '0;
    shape    = '0;
    hit_mask = '0;
    line_m   = '0;
    for (int k = 0; k < 9; k++) begin
      occ[k]   = board_q[2*k];
      shape[k] = board_q[2*k+1];
    end
    for (int l = 0; l < 8; l++) begin
      line_m = LINE_MASKS[9*l +: 9];
      if (((occ & line_m) == line_m) &&
          (((shape & line_m) == line_m) || ((shape & line_m) == 9'd0))) begin
        hit_mask = hit_mask | line_m;
      end
    end
    cur_idx    = (cursor_q > 4'd8) ? 4'd4 : cursor_q;
    cur_onehot = 9'd1 << cur_idx;
    cur_empty  = ~|(occ & cur_onehot);
  end

  // Row/column of the (sanitised) cursor for wrap-around movement.
  always_comb begin
    row = 2'd1;
    col = 2'd1;
    case (cur_idx)
      4'd0: begin row = 2'd0; col = 2'd0; end
      4'd1: begin row = 2'd0; col = 2'd1; end
      4'd2: begin row = 2'd0; col = 2'd2; end
      4'd3: begin row = 2'd1; col = 2'd0; end
      4'd5: begin row = 2'd1; col = 2'd2; end
      4'd6: begin row = 2'd2; col = 2'd0; end
      4'd7: begin row = 2'd2; col = 2'd1; end
      4'd8: begin row = 2'd2; col = 2'd2; end
      default: begin row = 2'd1; col = 2'd1; end
    endcase
  end

  // Game FSM: prioritised action selection, move placement, line evaluation and blink timing.
  always_comb begin
    state_d  = state_q;
    board_d  = board_q;
    cursor_d = cur_idx;
    turn_d   = turn_q;
    winner_d = winner_q;
    mask_d   = mask_q;
    cnt_d    = cnt_q;
    phase_d  = phase_q;
    row_n    = row;
    col_n    = col;
    if (new_game || (btn_select && (state_q == ST_WIN || state_q == ST_DRAW))) begin
      state_d  = ST_PLAY;
      board_d  = '0;
      cursor_d = 4'd4;
      turn_d   = 1'b0;
      winner_d = 2'b00;
      mask_d   = '0;
      cnt_d    = '0;
      phase_d  = 1'b1;
    end else begin
      case (state_q)
        ST_PLAY: begin
          if (btn_select) begin
            // Occupied tile: the select is simply dropped.
            if (cur_empty) begin
              for (int k = 0; k < 9; k++) begin
                if (4'(k) == cur_idx) board_d[2*k +: 2] = {~turn_q, 1'b1};
              end
              turn_d  = ~turn_q;
              state_d = ST_CHECK;
            end
          end else begin
            if (btn_up)         row_n = (row == 2'd0) ? 2'd2 : row - 2'd1;
            else if (btn_down)  row_n = (row == 2'd2) ? 2'd0 : row + 2'd1;
            else if (btn_left)  col_n = (col == 2'd0) ? 2'd2 : col - 2'd1;
            else if (btn_right) col_n = (col == 2'd2) ? 2'd0 : col + 2'd1;
            cursor_d = {2'b00, row_n} * 4'd3 + {2'b00, col_n};
          end
        end
        ST_CHECK: begin
          if (|hit_mask) begin
            state_d  = ST_WIN;
            // turn has already flipped, so the mover is the opposite of turn_q.
            winner_d = turn_q ? 2'b01 : 2'b10;
            mask_d   = hit_mask;
            cnt_d    = '0;
            phase_d  = 1'b1;
          end else if (&occ) begin
            state_d = ST_DRAW;
          end else begin
            state_d = ST_PLAY;
          end
        end
        ST_WIN: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Renderer view: board plus cursor preview in PLAY, cursor highlight or blinking win line.
  always_comb begin
    tiles_d = board_q;
    color_d = '0;
    case (state_q)
      ST_PLAY: begin
        if (cur_empty) begin
          for (int k = 0; k < 9; k++) begin
            if (4'(k) == cur_idx) tiles_d[2*k +: 2] = {~turn_q, 1'b1};
          end
        end
        color_d = cur_onehot;
      end
      ST_CHECK: color_d = cur_onehot;
      ST_WIN:   color_d = mask_q & {9{phase_q}};
      default:  color_d = '0;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_PLAY;
      board_q  <= '0;
      cursor_q <= 4'd4;
      turn_q   <= 1'b0;
      winner_q <= 2'b00;
      mask_q   <= '0;
      cnt_q    <= '0;
      phase_q  <= 1'b1;
      tiles_q  <= '0;
      color_q  <= '0;
    end else begin
      state_q  <= state_d;
      board_q  <= board_d;
      cursor_q <= cursor_d;
      turn_q   <= turn_d;
      winner_q <= winner_d;
      mask_q   <= mask_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      tiles_q  <= tiles_d;
      color_q  <= color_d;
    end
  end

  assign tiles      = tiles_q;
  assign color      = color_q;
  assign game_state = state_q;
  assign winner     = winner_q;
  assign turn       = turn_q;
  assign cursor     = cursor_q;

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Bench for ttt_game_ctrl: directed scenarios then random button traffic against a board-level model.
module tb_ttt_game_ctrl;

  localparam int B = 4;

  localparam logic [5:0] IDLE = 6'b000000;
  localparam logic [5:0] NG   = 6'b100000;
  localparam logic [5:0] SEL  = 6'b010000;
  localparam logic [5:0] UP   = 6'b001000;
  localparam logic [5:0] DN   = 6'b000100;
  localparam logic [5:0] LF   = 6'b000010;
  localparam logic [5:0] RT   = 6'b000001;

  localparam int LN [24] = '{0,1,2, 3,4,5, 6,7,8, 0,3,6, 1,4,7, 2,5,8, 0,4,8, 2,4,6};

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic        btn_select = 1'b0, new_game = 1'b0;
  logic [17:0] tiles;
  logic [8:0]  color;
  logic [1:0]  game_state;
  logic [1:0]  winner;
  logic        turn;
  logic [3:0]  cursor;

  ttt_game_ctrl #(.BLINK_CYCLES(B)) dut (
    .clk(clk), .reset(reset),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .btn_select(btn_select), .new_game(new_game),
    .tiles(tiles), .color(color), .game_state(game_state),
    .winner(winner), .turn(turn), .cursor(cursor)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: board[k] 0 empty / 1 P1 / 2 P2; states 0 PLAY 1 CHECK 2 WIN 3 DRAW; age = cycles spent in WIN.
  int m_board [9];
  int m_row, m_col, m_turn, m_state, m_winner, m_mask, m_age;
  int exp_t, exp_c;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic m_clear();
    for (int k = 0; k < 9; k++) m_board[k] = 0;
    m_row = 1; m_col = 1; m_turn = 0; m_state = 0; m_winner = 0; m_mask = 0; m_age = 0;
  endtask

  function automatic int r_tiles();
    int t = 0;
    for (int k = 0; k < 9; k++) begin
      int c = 0;
      if (m_board[k] == 1) c = 3;
      else if (m_board[k] == 2) c = 1;
      if (m_state == 0 && k == m_row*3 + m_col && m_board[k] == 0) c = (m_turn == 0) ? 3 : 1;
      t += c << (2*k);
    end
    return t;
  endfunction

  function automatic int r_color();
    if (m_state <= 1) return 1 << (m_row*3 + m_col);
    if (m_state == 2) return ((m_age / B) % 2 == 0) ? m_mask : 0;
    return 0;
  endfunction

  task automatic m_step(input logic [5:0] b);
    if (b[5] || (b[4] && m_state >= 2)) begin
      m_clear();
    end else if (m_state == 0) begin
      if (b[4]) begin
        int k = m_row*3 + m_col;
        if (m_board[k] == 0) begin
          m_board[k] = m_turn + 1;
          m_turn = 1 - m_turn;
          m_state = 1;
        end
      end
      else if (b[3]) m_row = (m_row + 2) % 3;
      else if (b[2]) m_row = (m_row + 1) % 3;
      else if (b[1]) m_col = (m_col + 2) % 3;
      else if (b[0]) m_col = (m_col + 1) % 3;
    end else if (m_state == 1) begin
      int mask = 0;
      bit full = 1;
      for (int l = 0; l < 8; l++) begin
        int a = LN[3*l], c1 = LN[3*l+1], c2 = LN[3*l+2];
        if (m_board[a] != 0 && m_board[a] == m_board[c1] && m_board[a] == m_board[c2])
          mask = mask | (1 << a) | (1 << c1) | (1 << c2);
      end
      for (int k = 0; k < 9; k++) if (m_board[k] == 0) full = 0;
      if (mask != 0) begin
        m_state = 2; m_mask = mask; m_age = 0;
        m_winner = (m_turn == 1) ? 1 : 2;
      end else if (full) m_state = 3;
      else m_state = 0;
    end else if (m_state == 2) begin
      m_age++;
    end
  endtask

  task automatic cycle(input logic [5:0] b);
    {new_game, btn_select, btn_up, btn_down, btn_left, btn_right} = b;
    exp_t = r_tiles();
    exp_c = r_color();
    m_step(b);
    @(posedge clk);
    #1;
    {new_game, btn_select, btn_up, btn_down, btn_left, btn_right} = IDLE;
    chk("game_state", 32'(game_state), m_state);
    chk("winner", 32'(winner), m_winner);
    chk("turn", 32'(turn), m_turn);
    chk("cursor", 32'(cursor), m_row*3 + m_col);
    chk("tiles", 32'(tiles), exp_t);
    chk("color", 32'(color), exp_c);
  endtask

  task automatic goto_tile(input int k);
    while (m_row != k / 3) cycle(UP);
    while (m_col != k % 3) cycle(RT);
  endtask

  task automatic play(input int k);
    goto_tile(k);
    cycle(SEL);
    cycle(IDLE);
  endtask

  task automatic win_row0();
    cycle(NG);
    play(0); play(3); play(1); play(4);
    goto_tile(2);
    cycle(SEL);
    chk("win_check_state", 32'(game_state), 32'd1);
    cycle(IDLE);
    chk("win_state", 32'(game_state), 32'd2);
    chk("win_winner", 32'(winner), 32'd1);
  endtask

  initial begin
    m_clear();
    // Reset held low: outputs at reset values.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tiles", 32'(tiles), 32'h0);
    chk("rst_color", 32'(color), 32'h0);
    chk("rst_state", 32'(game_state), 32'd0);
    chk("rst_cursor", 32'(cursor), 32'd4);
    chk("rst_turn", 32'(turn), 32'd0);
    chk("rst_winner", 32'(winner), 32'd0);
    reset = 1'b1;
    cycle(IDLE);
    chk("t1_tiles", 32'(tiles), 32'h00300);
    chk("t1_color", 32'(color), 32'h010);

    // Cursor wrap and priority.
    cycle(UP); cycle(RT);
    cycle(RT);
    chk("t2_right_wrap", 32'(cursor), 32'd0);
    cycle(RT);
    cycle(UP);
    chk("t2_up_wrap", 32'(cursor), 32'd7);
    cycle(DN);
    chk("t2_down_wrap", 32'(cursor), 32'd1);
    cycle(UP | LF);
    chk("t2_up_over_left", 32'(cursor), 32'd7);

    // Select on an occupied tile is ignored.
    cycle(NG);
    goto_tile(4);
    cycle(SEL);
    cycle(IDLE);
    cycle(SEL);
    chk("t3_turn", 32'(turn), 32'd1);
    chk("t3_state", 32'(game_state), 32'd0);
    cycle(IDLE);
    chk("t3_tile4", 32'(tiles[9:8]), 32'd3);

    // Win on row 0 and blink (directional buttons ignored).
    win_row0();
    cycle(RT);
    chk("t4_color_on", 32'(color), 32'h007);
    cycle(UP); cycle(LF); cycle(DN); cycle(IDLE);
    chk("t4_color_off", 32'(color), 32'h000);
    for (int i = 0; i < 12; i++) cycle(6'(1 << $urandom_range(0, 3)));

    // Draw, then select restarts.
    cycle(NG);
    play(0); play(1); play(2); play(4); play(3); play(5); play(7); play(6);
    goto_tile(8);
    cycle(SEL);
    cycle(IDLE);
    chk("t5_state", 32'(game_state), 32'd3);
    chk("t5_winner", 32'(winner), 32'd0);
    cycle(IDLE);
    chk("t5_color", 32'(color), 32'h0);
    cycle(SEL);
    chk("t5_restart", 32'(game_state), 32'd0);
    cycle(IDLE);
    chk("t5_tiles", 32'(tiles), 32'h00300);

    // new_game beats select mid-game.
    play(0); play(1);
    cycle(NG | SEL);
    chk("t6_state", 32'(game_state), 32'd0);
    chk("t6_turn", 32'(turn), 32'd0);
    cycle(IDLE);
    chk("t6_tiles", 32'(tiles), 32'h00300);

    // Async reset during WIN.
    win_row0();
    cycle(IDLE);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_tiles", 32'(tiles), 32'h0);
    chk("ar_color", 32'(color), 32'h0);
    chk("ar_state", 32'(game_state), 32'd0);
    chk("ar_winner", 32'(winner), 32'd0);
    chk("ar_cursor", 32'(cursor), 32'd4);
    chk("ar_turn", 32'(turn), 32'd0);
    m_clear();
    @(posedge clk);
    #1;
    reset = 1'b1;
    cycle(IDLE);

    // Random traffic, including simultaneous buttons.
    for (int i = 0; i < 3000; i++) begin
      int r = $urandom_range(0, 99);
      logic [5:0] b;
      if (r < 2)       b = NG;
      else if (r < 30) b = SEL;
      else if (r < 40) b = 6'($urandom_range(0, 31));
      else if (r < 90) b = 6'(1 << $urandom_range(0, 3));
      else             b = IDLE;
      cycle(b);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
